// File: rtl/disp_arbiter_if.sv
// Bundles the requester, display-value and status signals of disp_arbiter.
// The master side drives requests and data, and the slave side is the arbiter.
interface disp_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   data_flat;
    logic                 hold;
    logic [31:0]          x;
    logic                 valid;
    logic [NREQ-1:0]      grant;
    logic [OW-1:0]        owner;
    logic                 switch_pulse;

    modport master (
        output req, data_flat, hold,
        input  x, valid, grant, owner, switch_pulse
    );

    modport slave (
        input  req, data_flat, hold,
        output x, valid, grant, owner, switch_pulse
    );
endinterface

// File: rtl/disp_arbiter.sv
// Time-sliced round-robin owner selection for the shared 8-digit display.
// DISP_ARB_LATCH_EN: when defined, x is captured once per slice instead of following live data.
module disp_arbiter #(
    parameter int          NREQ     = 4,
    parameter int          DWELL    = 50_000_000,
    parameter int          GAP      = 0,
    parameter logic [31:0] IDLE_VAL = 32'h0
) (
    input logic           clk,
    input logic           rst_n,
    disp_arbiter_if.slave bus
);
    localparam int OW = $clog2(NREQ);
    localparam int DW = $clog2(DWELL + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    state_t          state_r, state_n;
    logic [OW-1:0]   owner_r, owner_n;
    logic [OW-1:0]   rr_ptr_r, rr_n;
    logic [DW-1:0]   dwell_r, dwell_n;
    logic [GW-1:0]   gap_r, gap_n;
    logic [31:0]     x_r, x_n;
    logic            valid_r, valid_n;
    logic [NREQ-1:0] grant_r, grant_n;
    logic            sw_r, sw_n;
    logic            cap_s, launch_s, others_s;
    logic [OW-1:0]   pick_s;

    // First requester after ptr, wrapping; the search reaches ptr itself last.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] rq, input logic [OW-1:0] ptr);
        logic [OW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && rq[idx[OW-1:0]]) begin
                sel   = idx[OW-1:0];
                found = 1'b1;
            end else begin
                sel   = sel;
            end
        end
        return sel;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] i);
        return {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    function automatic logic [31:0] sel_data(input logic [32*NREQ-1:0] d, input logic [OW-1:0] i);
        return d[32*i +: 32];
    endfunction

    // Next-state, counter and owner selection.
    always_comb begin
        state_n  = state_r;
        owner_n  = owner_r;
        rr_n     = rr_ptr_r;
        dwell_n  = dwell_r;
        gap_n    = gap_r;
        sw_n     = 1'b0;
        cap_s    = 1'b0;
        launch_s = 1'b0;
        pick_s   = rr_pick(bus.req, rr_ptr_r);
        others_s = |(bus.req & ~onehot(owner_r));
        case (state_r)
            ST_IDLE: begin
                if (|bus.req) begin
                    launch_s = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_r == '0) begin
                    state_n = ST_SHOW;
                    dwell_n = DW'(DWELL - 1);
                    sw_n    = 1'b1;
                    cap_s   = 1'b1;
                end else begin
                    gap_n = gap_r - GW'(1);
                end
            end
            ST_SHOW: begin
                // An owner drop overrides both hold and the remaining dwell.
                if (!bus.req[owner_r]) begin
                    if (|bus.req) begin
                        launch_s = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        dwell_n = '0;
                    end
                end else if ((dwell_r == '0) && !bus.hold) begin
                    if (others_s) begin
                        launch_s = 1'b1;
                    end else begin
                        dwell_n = DW'(DWELL - 1);
                        cap_s   = 1'b1;
                    end
                end else if (!bus.hold) begin
                    dwell_n = dwell_r - DW'(1);
                end else begin
                    dwell_n = dwell_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (launch_s) begin
            owner_n = pick_s;
            rr_n    = pick_s;
            if (GAP > 0) begin
                state_n = ST_GAP;
                gap_n   = GW'(GAP - 1);
                dwell_n = '0;
            end else begin
                state_n = ST_SHOW;
                dwell_n = DW'(DWELL - 1);
                sw_n    = 1'b1;
                cap_s   = 1'b1;
            end
        end else begin
            owner_n = owner_n;
        end
    end

    // Registered outputs derived from the next state.
    always_comb begin
        valid_n = (state_n == ST_SHOW);
        grant_n = valid_n ? onehot(owner_n) : '0;
`ifdef DISP_ARB_LATCH_EN
        x_n = valid_n ? (cap_s ? sel_data(bus.data_flat, owner_n) : x_r) : IDLE_VAL;
`else
        x_n = valid_n ? sel_data(bus.data_flat, owner_n) : IDLE_VAL;
`endif
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            owner_r  <= '0;
            rr_ptr_r <= OW'(NREQ - 1);
            dwell_r  <= '0;
            gap_r    <= '0;
            x_r      <= IDLE_VAL;
            valid_r  <= 1'b0;
            grant_r  <= '0;
            sw_r     <= 1'b0;
        end else begin
            state_r  <= state_n;
            owner_r  <= owner_n;
            rr_ptr_r <= rr_n;
            dwell_r  <= dwell_n;
            gap_r    <= gap_n;
            x_r      <= x_n;
            valid_r  <= valid_n;
            grant_r  <= grant_n;
            sw_r     <= sw_n;
        end
    end

    assign bus.x            = x_r;
    assign bus.valid        = valid_r;
    assign bus.grant        = grant_r;
    assign bus.owner        = owner_r;
    assign bus.switch_pulse = sw_r;
endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter: one GAP=0 instance and one GAP=2 instance.
module tb_disp_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    disp_arbiter_if #(.NREQ(4)) bus_a ();
    disp_arbiter_if #(.NREQ(4)) bus_b ();

    disp_arbiter #(.NREQ(4), .DWELL(4), .GAP(0), .IDLE_VAL(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    disp_arbiter #(.NREQ(4), .DWELL(4), .GAP(2), .IDLE_VAL(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

`ifdef DISP_ARB_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ex_x;
    logic [3:0]  ex_g;
    logic        ex_v;
    logic        ex_s;
    logic [1:0]  ex_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus_a.req       = 4'b0000;
        bus_a.hold      = 1'b0;
        bus_a.data_flat = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_000A};
        bus_b.req       = 4'b0000;
        bus_b.hold      = 1'b0;
        bus_b.data_flat = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
        #12;
        chk("rst_valid", 32'(bus_a.valid), 32'h0);
        chk("rst_grant", 32'(bus_a.grant), 32'h0);
        chk("rst_owner", 32'(bus_a.owner), 32'h0);
        chk("rst_x", bus_a.x, 32'h0);
        chk("rst_sw", 32'(bus_a.switch_pulse), 32'h0);
        chk("rst_x_b", bus_b.x, 32'hDEAD_BEEF);
        @(negedge clk);
        rst_n = 1'b1;

        // No requests: display stays idle.
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_state", {bus_a.x, 28'(bus_a.grant), 4'(bus_a.valid), 4'(bus_a.switch_pulse)} == '0 ? 32'h0 : 32'h1, 32'h0);
        end

        // Alternating owners 1 and 3.
        bus_a.req = 4'b1010;
        for (int c = 1; c <= 12; c++) begin
            step();
            ex_g = (((c - 1) / 4) % 2 == 0) ? 4'b0010 : 4'b1000;
            ex_x = (((c - 1) / 4) % 2 == 0) ? 32'h1111_1111 : 32'h3333_3333;
            ex_s = ((c - 1) % 4 == 0);
            chk("rr_grant", 32'(bus_a.grant), 32'(ex_g));
            chk("rr_x", bus_a.x, ex_x);
            chk("rr_sw", 32'(bus_a.switch_pulse), 32'(ex_s));
        end
        bus_a.req = 4'b0000;
        step();
        chk("rr_to_idle", 32'(bus_a.valid), 32'h0);
        chk("rr_idle_x", bus_a.x, 32'h0);

        // Single steady requester reloads without switch pulses.
        bus_a.req = 4'b0100;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk("solo_grant", 32'(bus_a.grant), 32'h4);
            chk("solo_x", bus_a.x, 32'h2222_2222);
            chk("solo_sw", 32'(bus_a.switch_pulse), 32'(c == 1));
        end
        bus_a.req = 4'b0000;
        step();
        chk("solo_to_idle", 32'(bus_a.valid), 32'h0);

        // Owner drop mid-slice hands over on the next edge.
        bus_a.req = 4'b0010;
        step();
        chk("drop_g1", 32'(bus_a.grant), 32'h2);
        step();
        chk("drop_g2", 32'(bus_a.grant), 32'h2);
        bus_a.req = 4'b1000;
        step();
        chk("drop_grant", 32'(bus_a.grant), 32'h8);
        chk("drop_sw", 32'(bus_a.switch_pulse), 32'h1);
        chk("drop_owner", 32'(bus_a.owner), 32'h3);
        bus_a.req = 4'b0000;
        step();
        chk("drop_idle", 32'(bus_a.valid), 32'h0);

        // Three hold cycles stretch the slice to seven cycles.
        bus_a.req = 4'b1010;
        step();
        chk("hold_e1", 32'(bus_a.grant), 32'h2);
        bus_a.hold = 1'b1;
        for (int e = 2; e <= 7; e++) begin
            step();
            chk("hold_slice", 32'(bus_a.grant), 32'h2);
            if (e == 4) bus_a.hold = 1'b0;
        end
        step();
        chk("hold_switch", 32'(bus_a.grant), 32'h8);
        chk("hold_sw", 32'(bus_a.switch_pulse), 32'h1);
        bus_a.req = 4'b0000;
        step();
        chk("hold_idle", 32'(bus_a.valid), 32'h0);

        // Data change mid-slice: latched vs live display value.
        bus_a.req = 4'b0001;
        step();
        chk("lat_owner", 32'(bus_a.owner), 32'h0);
        chk("lat_x0", bus_a.x, 32'h0000_000A);
        bus_a.data_flat[31:0] = 32'h0000_000B;
        for (int e = 2; e <= 4; e++) begin
            step();
            chk("lat_x_mid", bus_a.x, LATCH ? 32'h0000_000A : 32'h0000_000B);
        end
        step();
        chk("lat_x_reload", bus_a.x, 32'h0000_000B);
        chk("lat_reload_sw", 32'(bus_a.switch_pulse), 32'h0);
        chk("lat_reload_g", 32'(bus_a.grant), 32'h1);

        // Reset mid-slice clears rr_ptr, so requester 0 wins over 3.
        bus_a.req = 4'b1001;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(bus_a.valid), 32'h0);
        chk("mrst_grant", 32'(bus_a.grant), 32'h0);
        chk("mrst_x", bus_a.x, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mrst_owner", 32'(bus_a.owner), 32'h0);
        chk("mrst_g", 32'(bus_a.grant), 32'h1);
        chk("mrst_sw", 32'(bus_a.switch_pulse), 32'h1);
        bus_a.req = 4'b0000;

        // GAP=2 instance: two blank cycles before each owner.
        bus_b.req = 4'b0011;
        for (int e = 1; e <= 9; e++) begin
            step();
            ex_v = (e >= 3 && e <= 6) || (e == 9);
            ex_g = (e >= 3 && e <= 6) ? 4'b0001 : ((e == 9) ? 4'b0010 : 4'b0000);
            ex_o = (e <= 6) ? 2'd0 : 2'd1;
            ex_x = (e >= 3 && e <= 6) ? 32'hB0B0_B0B0 : ((e == 9) ? 32'hB1B1_B1B1 : 32'hDEAD_BEEF);
            ex_s = (e == 3) || (e == 9);
            chk("gap_valid", 32'(bus_b.valid), 32'(ex_v));
            chk("gap_grant", 32'(bus_b.grant), 32'(ex_g));
            chk("gap_owner", 32'(bus_b.owner), 32'(ex_o));
            chk("gap_x", bus_b.x, ex_x);
            chk("gap_sw", 32'(bus_b.switch_pulse), 32'(ex_s));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Time-sliced arbiter that shares the single 8-digit seven-segment display between up to NREQ requesters, such as the CPU result register, the PC and debug probes. It picks an owner round-robin, holds that owner on the display for a fixed dwell period, and optionally inserts a blank gap between owners. It presents the 32-bit value that drives the display driver's `x` input. It sits between the CPU debug taps and the display driver, on the same `clk`.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DWELL, 50_000_000: display cycles per owner slice, ≥1.
- GAP, 0: blank cycles between owners; 0 means no blank.
- IDLE_VAL, 32'h0: value on `x` when nobody owns the display.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester, level-sensitive.
- data_flat  in  32*NREQ  requester i value at bits [32*i+31:32*i].
- hold  in  1  freezes the dwell countdown of the current owner.
- x  out  32  value to the display driver.
- valid  out  1  an owner is on the display (SHOW state).
- grant  out  NREQ  one-hot current owner; 0 when not in SHOW.
- owner  out  $clog2(NREQ)  index of current or pending owner.
- switch_pulse  out  1  one-cycle strobe on each entry into SHOW with a new owner.

## Operation
- States: IDLE, GAP, SHOW. `rr_ptr` holds the last owner.
- Round-robin pick: first i with req[i]=1, searching rr_ptr+1, rr_ptr+2, … with wrap mod NREQ.
- IDLE, any req set: pick owner, set rr_ptr=owner.
  - GAP>0: go to GAP with gap counter = GAP-1.
  - GAP=0: go to SHOW with dwell counter = DWELL-1 and switch_pulse=1.
- GAP: counts down, ignoring req and hold. At 0 it enters SHOW for the committed owner with dwell counter = DWELL-1 and switch_pulse=1.
- SHOW: the dwell counter decrements each cycle when hold=0 and is frozen when hold=1.
- SHOW exit on owner drop: if req[owner]=0, exit at the next edge regardless of hold or counter value. Go to GAP or SHOW for the next pick if any req is set, else IDLE.
- SHOW, counter=0 and hold=0:
  - Another requester is set: switch to it, via GAP if GAP>0.
  - Only the owner is set: reload to DWELL-1 and stay, with no switch_pulse.
  - None set: go to IDLE.
- `x`:
  - SHOW: data of owner (see Configuration).
  - IDLE and GAP: IDLE_VAL.
- Width rules: counter width is $clog2(DWELL+1). Counters never underflow. rr_ptr wraps NREQ-1 → 0.

## Timing
- Reset (async assert, sync deassert):
  - state=IDLE, rr_ptr=NREQ-1 so requester 0 wins first.
  - valid=0, grant=0, owner=0, switch_pulse=0, x=IDLE_VAL, both counters=0.
- All outputs are registered and update on the same `clk` edge.
- Latency, GAP=0: req sampled high at edge k gives grant/valid/switch_pulse high after edge k.
- Latency, GAP>0: grant rises GAP cycles later. `owner` is updated on GAP entry.
- Each owner holds SHOW for exactly DWELL cycles when hold=0 and no drop occurs. Each hold-high cycle extends the slice by one.
- Switch, GAP=0: one owner leaves and the next enters on the same edge. valid stays 1, grant changes one-hot, switch_pulse=1.
- DWELL=1: the owner switches every cycle while others are requesting.
- Owner req drop during GAP: SHOW is still entered and the drop is acted on one cycle later.
- Reset mid-slice: immediate IDLE. Slice progress and rr_ptr are lost.

## Configuration
- `DISP_ARB_LATCH_EN` defined:
  - `x` captures data_flat[owner] at the SHOW-entry or reload edge and holds it for the slice.
  - A DWELL-reload with the same owner re-captures.
- Undefined: in SHOW, `x` is a registered copy of live data_flat[owner], updated every cycle.

## Test plan
All scenarios use NREQ=4, DWELL=4, GAP=0, IDLE_VAL=0 unless stated.
- Reset, then req=4'b0000 for 10 cycles → valid=0, grant=0, x=0, switch_pulse never high.
- req=4'b1010, data1=32'h1111_1111, data3=32'h3333_3333 → grant 0010 for 4 cycles, then 1000 for 4 cycles, repeating. switch_pulse pulses at each change; x follows the owner.
- req=4'b0100 steady → grant=0100 continuously, switch_pulse only once, x=data2.
- Owner 1 active, req[1] drops at cycle 2 of the slice, req[3]=1 → grant=1000 on the next edge. hold=1 for 3 cycles while req[1] is held → slice lasts 7 cycles.
- GAP=2, req=4'b0011 → grant 0001 for 4 cycles, then 2 cycles valid=0 with x=0 and owner=1, then grant 0010.
- Latch build, owner 0, data0 changes 32'hA→32'hB mid-slice → x stays 32'hA until the slice ends. Non-latch build → x=32'hB one cycle after the change.
